uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Memory-mapped UART receiver on the picorv32 native memory bus; receive-side
//  counterpart of uartTx. Samples serialIn (8N1, LSB first), buffers bytes in a
//  small FIFO, exposes data/status registers. Selected by address_decoder enable.
// PARAMETERS
//  BAUD_DIV    434  clk cycles per bit (50 MHz / 115200); must be >= 16
//  FIFO_DEPTH  4    receive FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  enable     in   1   peripheral select from address_decoder
//  mem_valid  in   1   bus request valid
//  mem_ready  out  1   bus ack; high-Z when not selected
//  mem_instr  in   1   instruction fetch flag (unused; fetches read as data)
//  mem_wstrb  in   4   byte write strobes; 0 = read
//  mem_wdata  in   32  write data
//  mem_addr   in   32  byte address; bit[2] selects register
//  mem_rdata  out  32  read data; high-Z when not selected
//  serialIn   in   1   asynchronous RX line, idle high
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, sticky flags 0, sync flops 1, internal ready 0.
//  Input: 2-flop synchroniser on serialIn (reset value 1) before any use.
//  Registers: addr[2]=0 DATA (read: {24'b0, byte}, pops FIFO; write ignored);
//   addr[2]=1 STATUS (read: bit0 not_empty, bit1 overrun, bit2 frame_err,
//   bit3 full, rest 0; any write with nonzero wstrb clears bits 1,2).
//  Handshake: mem_valid & enable & !ready -> ready=1 next cycle for exactly
//   one cycle with rdata valid; then ready=0. One ack per transfer.
//   Pop/clear take effect on the ack cycle. Outputs 'z whenever !enable.
//  Read DATA while empty -> 0x00000000, no pop, no error.
//  FSM (bit counter 0..BAUD_DIV-1, index 0..7):
//   IDLE : sync line 1->0 -> START, counter=0.
//   START: at counter=BAUD_DIV/2-1 line still 0 -> DATA, counter=0;
//          line 1 -> IDLE (glitch rejected, nothing logged).
//   DATA : sample at each counter=BAUD_DIV-1 (mid-bit), shift in LSB first;
//          after 8th sample -> STOP.
//   STOP : sample at counter=BAUD_DIV-1: 1 -> push byte, IDLE;
//          0 -> discard byte, set frame_err, WAIT_HIGH.
//   WAIT_HIGH: stay until sync line=1 (break), then IDLE.
//  Push when full -> byte dropped, overrun set; FIFO contents unchanged.
//  Push and pop same cycle when full -> both succeed, no overrun.
//  Push and pop same cycle when empty -> pop returns 0, push lands; count=1.
//  Sticky clear coinciding with a new error event -> event wins (flag stays 1).
//  Latency: byte visible in STATUS.bit0 the cycle after the stop-bit sample.
//  Reset mid-frame: partial byte discarded, FSM IDLE immediately.
// STRUCTURE
//  Shared package/header: register offsets (DATA=0, STATUS=4), STATUS bit
//   positions, FSM state encodings.
//  Sub-module: sync_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty,
//   wrap-around pointers with extra MSB); FSM+baud counter and bus logic
//   stay in uart_rx.
// TESTING (BAUD_DIV=16 for speed)
//  Send 0xA5 8N1 -> STATUS=0x1; DATA read=0xA5; STATUS then 0x0.
//  Low pulse 4 clks on idle line -> no byte, STATUS=0x0, FSM back in IDLE.
//  Send 0x3C with stop bit 0, line held low 40 clks -> STATUS bit2=1,
//   FIFO empty; write STATUS -> 0x0; next 0x55 received normally.
//  Send 5 bytes 0x01..0x05, no reads -> STATUS=0xB (full, overrun,
//   not_empty); reads return 0x01..0x04, then empty read returns 0x00.
//  Assert reset during DATA bit 3 of 0xFF -> STATUS=0x0; next frame 0x12
//   received correctly.
//  Reads with enable=0 -> mem_ready/mem_rdata high-Z; no pop occurs.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//  Shared definitions for the memory-mapped UART receiver.
//  Contents:
//   - register byte offsets (DATA, STATUS) and the address bit that selects them
//   - STATUS register layout as a packed struct (bit0 .. bit3)
//   - receive FSM state encodings
//   - helper that widens the STATUS struct to a 32-bit bus word
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  // Register map: the two registers are told apart by a single address bit.
  localparam logic [31:0]  ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0]  ADDR_STATUS = 32'h0000_0004;
  localparam int unsigned  REG_SEL_BIT = 2;

  // Receive FSM encodings.
  localparam int unsigned  STATE_W     = 3;
  localparam logic [2:0]   S_IDLE      = 3'd0;
  localparam logic [2:0]   S_START     = 3'd1;
  localparam logic [2:0]   S_DATA      = 3'd2;
  localparam logic [2:0]   S_STOP      = 3'd3;
  localparam logic [2:0]   S_WAIT_HIGH = 3'd4;

  localparam int unsigned  BYTE_W      = 8;
  localparam int unsigned  BUS_W       = 32;

  // STATUS layout, MSB first: bit3 full, bit2 frame_err, bit1 overrun, bit0 not_empty.
  typedef struct packed {
    logic full;
    logic frame_err;
    logic overrun;
    logic not_empty;
  } rx_status_t;

  // Zero-extend the STATUS flags to a bus word.
  function automatic logic [BUS_W-1:0] status_word(input rx_status_t s);
    return {28'b0, s};
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_fifo
//  Single-clock FIFO for received bytes. Pointers carry one extra MSB so that
//  full and empty are distinguished without a separate count.
//  Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset (FIFO becomes empty)
//   i_push     write request; ignored when full unless a pop happens together
//   i_wdata    byte to write
//   i_pop      read request; ignored when empty
//   o_rdata_c  head-of-FIFO entry (meaningless while empty)
//   o_full_c   all entries occupied
//   o_empty_c  no entries occupied
// ---------------------------------------------------------------------------
module uart_rx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW      = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_do_push;
  logic             w_do_pop;

  // Same MSB -> empty when indices match; opposite MSB -> full when indices match.
  assign o_empty_c = (r_wptr == r_rptr);
  assign o_full_c  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata_c = r_mem[r_rptr[AW-1:0]];

  // A pop from a full FIFO frees the slot that a simultaneous push fills.
  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);

  // Pointer update.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  Memory-mapped 8N1 UART receiver on the picorv32 native memory bus.
//  Samples serialIn (LSB first), buffers bytes in a small FIFO and exposes a
//  DATA register (read pops) and a STATUS register (write clears sticky flags).
//  Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   enable     peripheral select from the address decoder
//   mem_valid  bus request valid
//   mem_ready  one-cycle bus acknowledge; high-Z while not selected
//   mem_instr  instruction-fetch flag (fetches behave as data reads)
//   mem_wstrb  byte write strobes; all zero means read
//   mem_wdata  write data (content ignored)
//   mem_addr   byte address; bit 2 selects DATA(0) / STATUS(1)
//   mem_rdata  read data; high-Z while not selected
//   serialIn   asynchronous receive line, idle high
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam int unsigned    CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Line synchroniser and edge history.
  logic r_sync1;
  logic r_sync2;
  logic r_line_prev;
  logic w_line;

  // Receive FSM.
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nx;
  logic [BYTE_W-1:0]  r_shift;
  logic [BYTE_W-1:0]  w_shift_nx;
  logic               w_push;
  logic               w_frame_evt;

  // FIFO interface.
  logic [BYTE_W-1:0]  w_fifo_rdata;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_ovr_evt;

  // Bus side.
  logic               r_ready;
  logic [BUS_W-1:0]   r_rdata;
  logic [BUS_W-1:0]   w_rdata_nx;
  logic               w_req;
  logic               w_is_write;
  logic               w_sel_data;
  logic               w_sel_status;
  logic               w_clear;
  logic               r_overrun;
  logic               r_frame_err;
  rx_status_t         w_status;

  // Inputs with no function in this peripheral.
  logic               w_unused;
  assign w_unused = ^{mem_instr, mem_wdata, mem_addr[31:3], mem_addr[1:0]};

  assign w_line = r_sync2;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= serialIn;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  // FSM state register with its counters and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
    end
  end

  // Next-state logic: start bit checked at half a bit, data/stop at one bit later each.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + CNT_ONE;
    w_idx_nx    = r_idx;
    w_shift_nx  = r_shift;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (r_line_prev && !w_line) w_state_nx = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nx = '0;
          w_idx_nx = '0;
          // A line that is high again by mid-start-bit was only a glitch.
          w_state_nx = w_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_line, r_shift[BYTE_W-1:1]};
          w_idx_nx   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx = '0;
          if (w_line) begin
            w_push     = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_frame_evt = 1'b1;
            w_state_nx  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the break ends so its falling edge is not a start bit.
        w_cnt_nx = '0;
        if (w_line) w_state_nx = S_IDLE;
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Receive byte buffer.
  uart_rx_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_push    (w_push),
    .i_wdata   (w_shift_nx),
    .i_pop     (w_pop),
    .o_rdata_c (w_fifo_rdata),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Bus decode: a request is accepted only while no ack is outstanding.
  assign w_req        = mem_valid & enable & ~r_ready;
  assign w_is_write   = |mem_wstrb;
  assign w_sel_data   = (mem_addr[REG_SEL_BIT] == ADDR_DATA[REG_SEL_BIT]);
  assign w_sel_status = (mem_addr[REG_SEL_BIT] == ADDR_STATUS[REG_SEL_BIT]);
  assign w_pop        = w_req & ~w_is_write & w_sel_data;
  assign w_clear      = w_req &  w_is_write & w_sel_status;
  assign w_ovr_evt    = w_push & w_full & ~w_pop;

  always_comb begin
    w_status.full      = w_full;
    w_status.frame_err = r_frame_err;
    w_status.overrun   = r_overrun;
    w_status.not_empty = ~w_empty;
  end

  // Read data captured with the request so it is stable during the ack cycle.
  always_comb begin
    w_rdata_nx = '0;
    if (!w_is_write) begin
      if (w_sel_status)  w_rdata_nx = status_word(w_status);
      else if (!w_empty) w_rdata_nx = {24'b0, w_fifo_rdata};
    end
  end

  // Ack, read data and sticky flags; a new error event overrides a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ready     <= w_req;
      if (w_req) r_rdata <= w_rdata_nx;
      r_overrun   <= w_ovr_evt   | (r_overrun   & ~w_clear);
      r_frame_err <= w_frame_evt | (r_frame_err & ~w_clear);
    end
  end

  // Release the shared bus when not selected.
  assign mem_ready = enable ? r_ready : 1'bz;
  assign mem_rdata = enable ? r_rdata : {BUS_W{1'bz}};

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//  Self-checking bench for uart_rx with BAUD_DIV=16, FIFO_DEPTH=4.
//  A table of bus/serial operations with expected results, a few hand-written
//  corner sequences, and a random phase compared against a queue-based model.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned BAUD  = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        serialIn;
  wire         mem_ready;
  wire  [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  uart_rx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_SEND, OP_SEND_BAD, OP_RD_ST, OP_RD_DATA, OP_WR_ST, OP_WR_DATA} op_t;
  typedef struct {
    op_t         op;
    logic [7:0]  val;
    logic [31:0] exp;
  } vec_t;

  vec_t vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One bus transfer; the ack is awaited for a bounded number of cycles.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          output logic [31:0] rd);
    int n;
    n = 0;
    rd = '0;
    @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = $urandom;
    mem_instr = 1'($urandom_range(0, 1));
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mem_ready !== 1'b1 && n < 8);
    check("ack", {31'b0, mem_ready}, 32'h1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(32'h4, 4'h0, r);
    check(name, r, exp);
  endtask

  task automatic rd_data(input string name, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(32'h0, 4'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr_reg(input logic [31:0] addr);
    logic [31:0] r;
    bus_xfer(addr, 4'($urandom_range(1, 15)), r);
  endtask

  // 8N1 frame; a bad stop bit is held low for stop_len cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    @(negedge clk);
    serialIn = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serialIn = d[i];
      repeat (BAUD) @(negedge clk);
    end
    serialIn = stop;
    repeat (stop ? BAUD : stop_len) @(negedge clk);
    serialIn = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  // Reference model state for the random phase.
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_fe;

  function automatic logic [31:0] model_status();
    return {28'b0, (mq.size() == DEPTH), m_fe, m_ovr, (mq.size() != 0)};
  endfunction

  initial begin
    logic [31:0] r;
    reset     = 1'b1;
    enable    = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = '0;
    mem_addr  = '0;
    serialIn  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    rd_status("rst_status", 32'h0);
    rd_data("rst_empty_read", 32'h0);

    // Directed table: nominal byte, frame error + clear, overrun.
    vec.push_back('{OP_SEND,    8'hA5, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h1});
    vec.push_back('{OP_RD_DATA, 8'h00, 32'hA5});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h0});
    vec.push_back('{OP_SEND_BAD,8'h3C, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h4});
    vec.push_back('{OP_WR_ST,   8'h00, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h0});
    vec.push_back('{OP_SEND,    8'h55, 32'h0});
    vec.push_back('{OP_WR_DATA, 8'h00, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h1});
    vec.push_back('{OP_RD_DATA, 8'h00, 32'h55});
    for (int b = 1; b <= 5; b++) vec.push_back('{OP_SEND, 8'(b), 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'hB});
    for (int b = 1; b <= 4; b++) vec.push_back('{OP_RD_DATA, 8'h00, 32'(b)});
    vec.push_back('{OP_RD_DATA, 8'h00, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h2});
    vec.push_back('{OP_WR_ST,   8'h00, 32'h0});
    vec.push_back('{OP_RD_ST,   8'h00, 32'h0});

    for (int i = 0; i < vec.size(); i++) begin
      case (vec[i].op)
        OP_SEND:     send_frame(vec[i].val, 1'b1, 0);
        OP_SEND_BAD: send_frame(vec[i].val, 1'b0, 40);
        OP_RD_ST:    rd_status($sformatf("vec%0d_status", i), vec[i].exp);
        OP_RD_DATA:  rd_data($sformatf("vec%0d_data", i), vec[i].exp);
        OP_WR_ST:    wr_reg(32'h4);
        OP_WR_DATA:  wr_reg(32'h0);
        default:     ;
      endcase
    end

    // Short low glitch on an idle line is rejected; next frame still works.
    @(negedge clk);
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    rd_status("glitch_status", 32'h0);
    send_frame(8'hC3, 1'b1, 0);
    rd_status("post_glitch_status", 32'h1);
    rd_data("post_glitch_data", 32'hC3);

    // Reset in the middle of data bit 3 of 0xFF, with a stale byte queued.
    send_frame(8'h99, 1'b1, 0);
    @(negedge clk);
    serialIn = 1'b0;
    repeat (BAUD) @(negedge clk);
    serialIn = 1'b1;
    repeat (3 * BAUD + BAUD / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8 * BAUD) @(negedge clk);
    rd_status("midreset_status", 32'h0);
    send_frame(8'h12, 1'b1, 0);
    rd_status("post_reset_status", 32'h1);
    rd_data("post_reset_data", 32'h12);

    // Deselected reads: bus released, nothing popped.
    send_frame(8'h77, 1'b1, 0);
    @(negedge clk);
    enable    = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("desel_ready", {31'b0, (mem_ready === 1'b1)}, 32'h0);
      check("desel_rdata_released",
            {31'b0, ((mem_rdata === {32{1'bz}}) || (mem_rdata === 32'h0))}, 32'h1);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    enable    = 1'b1;
    repeat (2) @(negedge clk);
    rd_status("desel_status", 32'h1);
    rd_data("desel_data", 32'h77);

    // Random phase against a queue model.
    do_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    for (int it = 0; it < 50; it++) begin
      int unsigned op;
      logic [7:0]  d;
      op = $urandom_range(0, 6);
      d  = 8'($urandom);
      case (op)
        0, 1, 2: begin
          if ($urandom_range(0, 7) == 0) begin
            send_frame(d, 1'b0, 40);
            m_fe = 1'b1;
          end else begin
            send_frame(d, 1'b1, 0);
            if (mq.size() < DEPTH) mq.push_back(d);
            else                   m_ovr = 1'b1;
          end
        end
        3: rd_status($sformatf("rand%0d_status", it), model_status());
        4, 5: begin
          logic [31:0] e;
          e = (mq.size() != 0) ? {24'b0, mq.pop_front()} : 32'h0;
          rd_data($sformatf("rand%0d_data", it), e);
        end
        default: begin
          wr_reg(32'h4);
          m_ovr = 1'b0;
          m_fe  = 1'b0;
        end
      endcase
    end
    rd_status("rand_final_status", model_status());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
